// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with a small show-ahead receive FIFO and sticky error flags.
// Sampling runs on the synchronised line; all outputs come straight from flops.
module uart_rx_fifo #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DIV_W-1:0]  baud_div,
    input  logic              rx,
    input  logic              rd_en,
    input  logic              err_clr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rx_valid,
    output logic              fifo_full,
    output logic              frame_err,
    output logic              overrun_err
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int BIT_W = $clog2(DATA_W + 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

    logic              sync1_q, rxs_q, rxs_prev_q;
    state_t            state_q, state_d;
    logic [DIV_W-1:0]  cnt_q, cnt_d, half_s;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rx_valid_q, fifo_full_q, frame_err_q, overrun_q;
    logic              frame_err_d, overrun_d;
    logic              push_s, frame_set_s, pop_s, full_s, do_push_s, overrun_set_s;

    assign half_s = baud_div >> 1;

    // Two-flop synchroniser plus previous-sample flop for start-edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q    <= 1'b1;
            rxs_q      <= 1'b1;
            rxs_prev_q <= 1'b1;
        end else begin
            sync1_q    <= rx;
            rxs_q      <= sync1_q;
            rxs_prev_q <= rxs_q;
        end
    end

    // Receive FSM next state: START samples mid-bit, DATA/STOP one full bit later
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + DIV_W'(1);
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        push_s      = 1'b0;
        frame_set_s = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!rxs_q && rxs_prev_q) begin
                    state_d   = S_START;
                    bit_cnt_d = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                if (cnt_q == half_s - DIV_W'(1)) begin
                    cnt_d   = '0;
                    state_d = rxs_q ? S_IDLE : S_DATA;
                end else begin
                    state_d = S_START;
                end
            end
            S_DATA: begin
                if (cnt_q == baud_div - DIV_W'(1)) begin
                    cnt_d     = '0;
                    shift_d   = {rxs_q, shift_q[DATA_W-1:1]};
                    bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    state_d   = (bit_cnt_q == BIT_W'(DATA_W - 1)) ? S_STOP : S_DATA;
                end else begin
                    state_d = S_DATA;
                end
            end
            S_STOP: begin
                if (cnt_q == baud_div - DIV_W'(1)) begin
                    cnt_d = '0;
                    if (rxs_q) begin
                        push_s  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        frame_set_s = 1'b1;
                        state_d     = S_BREAK;
                    end
                end else begin
                    state_d = S_STOP;
                end
            end
            S_BREAK: begin
                cnt_d   = '0;
                state_d = rxs_q ? S_IDLE : S_BREAK;
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
        // Divisors below 4 leave no room for a mid-bit sample, so reception is parked
        if (baud_div < DIV_W'(4)) begin
            state_d     = S_IDLE;
            cnt_d       = '0;
            push_s      = 1'b0;
            frame_set_s = 1'b0;
        end else begin
            state_d = state_d;
        end
    end

    // FIFO bookkeeping: a push into a full FIFO survives only with a simultaneous pop
    always_comb begin
        full_s        = (count_q == CNT_W'(FIFO_DEPTH));
        pop_s         = rd_en && (count_q != '0);
        do_push_s     = push_s && (!full_s || pop_s);
        overrun_set_s = push_s && full_s && !pop_s;
        mem_d         = mem_q;
        if (do_push_s) begin
            mem_d[wr_ptr_q] = shift_q;
        end else begin
            mem_d = mem_q;
        end
        wr_ptr_d = do_push_s ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop_s ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        case ({do_push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        rd_data_d   = mem_d[rd_ptr_d];
        frame_err_d = frame_set_s || (frame_err_q && !err_clr);
        overrun_d   = overrun_set_s || (overrun_q && !err_clr);
    end

    // State, datapath and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rd_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            fifo_full_q <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rd_data_q   <= rd_data_d;
            rx_valid_q  <= (count_d != '0);
            fifo_full_q <= (count_d == CNT_W'(FIFO_DEPTH));
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign rd_data     = rd_data_q;
    assign rx_valid    = rx_valid_q;
    assign fifo_full   = fifo_full_q;
    assign frame_err   = frame_err_q;
    assign overrun_err = overrun_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: serial frames driven bit-by-bit, received
// bytes checked against a queue of expected values.
module tb_uart_rx_fifo;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] baud_div = 8'd130;
    logic       rx = 1'b1;
    logic       rd_en = 1'b0;
    logic       err_clr = 1'b0;
    logic [7:0] rd_data;
    logic       rx_valid, fifo_full, frame_err, overrun_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t_fall = 0;
    int rise_cyc = -1;
    logic rv_seen = 1'b0;
    logic [7:0] sb [$];

    uart_rx_fifo #(.DATA_W(8), .FIFO_DEPTH(4), .DIV_W(8)) dut (
        .clk(clk), .rst(rst), .baud_div(baud_div), .rx(rx), .rd_en(rd_en),
        .err_clr(err_clr), .rd_data(rd_data), .rx_valid(rx_valid),
        .fifo_full(fifo_full), .frame_err(frame_err), .overrun_err(overrun_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_valid && !rv_seen) rise_cyc = cyc;
        rv_seen = rx_valid;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives one frame; bad_stop holds the stop bit low for two bit times.
    // pop_k pulses rd_en after that edge index; abort_k asserts reset there.
    task automatic send_frame(input logic [7:0] d, input bit bad_stop,
                              input int pop_k, input int abort_k);
        int bd;
        int nstop;
        int total;
        int b;
        logic [7:0] exp;
        bd    = int'(baud_div);
        nstop = bad_stop ? 2 : 1;
        total = (10 + nstop) * bd;
        for (int k = 0; k < total; k++) begin
            @(posedge clk);
            #1;
            if (k == 0) t_fall = cyc;
            b = k / bd;
            if (b == 0)            rx = 1'b0;
            else if (b <= 8)       rx = d[b-1];
            else if (b <= 8 + nstop) rx = !bad_stop;
            else                   rx = 1'b1;
            if (k == pop_k) begin
                exp = sb.pop_front();
                chk("pop_on_push_head", {24'd0, rd_data}, {24'd0, exp});
                chk("pop_on_push_full", {31'd0, fifo_full}, 32'd1);
                rd_en = 1'b1;
            end else begin
                rd_en = 1'b0;
            end
            if (k == abort_k) begin
                rst = 1'b0;
                #1;
                chk("reset_outputs", {19'd0, rd_data, rx_valid, fifo_full, frame_err, overrun_err}, 32'd0);
                repeat (5) @(posedge clk);
                #1;
                rx  = 1'b1;
                rst = 1'b1;
                return;
            end
        end
    endtask

    task automatic read_check(input string tag);
        logic [7:0] exp;
        @(posedge clk);
        #1;
        exp = sb.pop_front();
        chk({tag, "_valid"}, {31'd0, rx_valid}, 32'd1);
        chk({tag, "_data"}, {24'd0, rd_data}, {24'd0, exp});
        rd_en = 1'b1;
        @(posedge clk);
        #1;
        rd_en = 1'b0;
    endtask

    task automatic pulse_clr();
        @(posedge clk);
        #1 err_clr = 1'b1;
        @(posedge clk);
        #1 err_clr = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", {19'd0, rd_data, rx_valid, fifo_full, frame_err, overrun_err}, 32'd0);
        rst = 1'b1;
        repeat (5) @(posedge clk);

        // 1: single frame, latency from falling edge to rx_valid
        send_frame(8'hAB, 1'b0, -1, -1);
        sb.push_back(8'hAB);
        chk("t1_latency", rise_cyc - t_fall, 32'd1238);
        chk("t1_errors", {30'd0, frame_err, overrun_err}, 32'd0);
        read_check("t1");
        chk("t1_empty", {31'd0, rx_valid}, 32'd0);

        // 2: short low glitch is a false start
        @(posedge clk);
        #1 rx = 1'b0;
        repeat (40) @(posedge clk);
        #1 rx = 1'b1;
        repeat (300) @(posedge clk);
        #1;
        chk("t2_no_push", {31'd0, rx_valid}, 32'd0);

        // 2b: divisor below 4 parks the receiver
        baud_div = 8'd3;
        send_frame(8'h5A, 1'b0, -1, -1);
        repeat (10) @(posedge clk);
        #1;
        chk("t2b_small_div", {31'd0, rx_valid}, 32'd0);
        baud_div = 8'd130;

        // 3: framing error, recovery, clear
        send_frame(8'h55, 1'b1, -1, -1);
        #1;
        chk("t3_frame_err", {31'd0, frame_err}, 32'd1);
        chk("t3_fifo_empty", {31'd0, rx_valid}, 32'd0);
        send_frame(8'h12, 1'b0, -1, -1);
        sb.push_back(8'h12);
        read_check("t3");
        pulse_clr();
        chk("t3_err_cleared", {31'd0, frame_err}, 32'd0);

        // 4: fill and overrun
        for (int i = 1; i <= 5; i++) begin
            send_frame(8'(i), 1'b0, -1, -1);
            if (i <= 4) sb.push_back(8'(i));
            if (i == 4) begin
                chk("t4_full", {31'd0, fifo_full}, 32'd1);
                chk("t4_no_overrun_yet", {31'd0, overrun_err}, 32'd0);
            end
        end
        chk("t4_overrun", {31'd0, overrun_err}, 32'd1);
        for (int i = 0; i < 4; i++) read_check("t4");
        chk("t4_drained", {31'd0, rx_valid}, 32'd0);
        pulse_clr();
        chk("t4_overrun_cleared", {31'd0, overrun_err}, 32'd0);

        // 5: pop on the same cycle a push lands into a full FIFO
        for (int i = 0; i < 4; i++) begin
            send_frame(8'h21 + 8'(i), 1'b0, -1, -1);
            sb.push_back(8'h21 + 8'(i));
        end
        send_frame(8'h77, 1'b0, 2 + 65 + 9 * 130, -1);
        sb.push_back(8'h77);
        chk("t5_still_full", {31'd0, fifo_full}, 32'd1);
        chk("t5_no_overrun", {31'd0, overrun_err}, 32'd0);
        for (int i = 0; i < 4; i++) read_check("t5");
        chk("t5_drained", {31'd0, rx_valid}, 32'd0);

        // 6: reset mid-frame discards both FIFO contents and the partial byte
        send_frame(8'h99, 1'b0, -1, -1);
        send_frame(8'hC3, 1'b0, -1, 5 * 130);
        repeat (5) @(posedge clk);
        send_frame(8'h3C, 1'b0, -1, -1);
        sb.push_back(8'h3C);
        read_check("t6");
        chk("t6_only_one", {31'd0, rx_valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
